lsu_sram_like: RTL

//  Multi-cycle load/store unit for the MEM stage that drives an SRAM-like data bus (req/addr_ok/data_ok).

---
 rtl/lsu_sram_like_pkg.sv | 75 +++++++
 rtl/lsu_lane_align.sv | 90 +++++++++
 rtl/lsu_sram_like.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lsu_sram_like_pkg.sv
// Shared opcode, size and FSM state encodings for the SRAM-like load/store unit.
// Opcode helpers decode size, direction, signedness and alignment for lsu_sram_like and lsu_lane_align.
package lsu_sram_like_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] LSU_OP_LB  = 4'd0;
  localparam logic [OP_W-1:0] LSU_OP_LBU = 4'd1;
  localparam logic [OP_W-1:0] LSU_OP_LH  = 4'd2;
  localparam logic [OP_W-1:0] LSU_OP_LHU = 4'd3;
  localparam logic [OP_W-1:0] LSU_OP_LW  = 4'd4;
  localparam logic [OP_W-1:0] LSU_OP_LWU = 4'd5;
  localparam logic [OP_W-1:0] LSU_OP_LD  = 4'd6;
  localparam logic [OP_W-1:0] LSU_OP_SB  = 4'd7;
  localparam logic [OP_W-1:0] LSU_OP_SH  = 4'd8;
  localparam logic [OP_W-1:0] LSU_OP_SW  = 4'd9;
  localparam logic [OP_W-1:0] LSU_OP_SD  = 4'd10;
  localparam logic [OP_W-1:0] LSU_OP_LWL = 4'd11;
  localparam logic [OP_W-1:0] LSU_OP_LWR = 4'd12;
  localparam logic [OP_W-1:0] LSU_OP_SWL = 4'd13;
  localparam logic [OP_W-1:0] LSU_OP_SWR = 4'd14;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;
  localparam logic [1:0] LSU_SIZE_D = 2'd3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_EXC  = 3'd4;

  function automatic logic [1:0] op_size(input logic [OP_W-1:0] op);
    case (op)
      LSU_OP_LB, LSU_OP_LBU, LSU_OP_SB: op_size = LSU_SIZE_B;
      LSU_OP_LH, LSU_OP_LHU, LSU_OP_SH: op_size = LSU_SIZE_H;
      LSU_OP_LD, LSU_OP_SD:             op_size = LSU_SIZE_D;
      default:                          op_size = LSU_SIZE_W;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [OP_W-1:0] op);
    op_is_store = (op == LSU_OP_SB) || (op == LSU_OP_SH) || (op == LSU_OP_SW) ||
                  (op == LSU_OP_SD) || (op == LSU_OP_SWL) || (op == LSU_OP_SWR);
  endfunction

  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
    op_is_signed = (op == LSU_OP_LB) || (op == LSU_OP_LH) || (op == LSU_OP_LW);
  endfunction

  function automatic logic op_is_lwlr(input logic [OP_W-1:0] op);
    op_is_lwlr = (op == LSU_OP_LWL) || (op == LSU_OP_LWR) ||
                 (op == LSU_OP_SWL) || (op == LSU_OP_SWR);
  endfunction

  function automatic logic op_known(input logic [OP_W-1:0] op);
    op_known = (op != 4'd15);
  endfunction

  // Unaligned-access opcodes are never misaligned by construction.
  function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [2:0] a);
    if (op_is_lwlr(op)) begin
      misaligned = 1'b0;
    end else begin
      case (op_size(op))
        LSU_SIZE_B: misaligned = 1'b0;
        LSU_SIZE_H: misaligned = a[0];
        LSU_SIZE_W: misaligned = |a[1:0];
        default:    misaligned = |a;
      endcase
    end
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extract/extend (and LWL/LWR merge), store replication and strobes.
// Optional feature macro: LSU_LWLR_EN (unaligned LWL/LWR/SWL/SWR, 32-bit bus only).
module lsu_lane_align
  import lsu_sram_like_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned NB     = DATA_W / 8,
  localparam int unsigned OFS    = $clog2(NB)
) (
  input  logic [OP_W-1:0]   op,
  input  logic [OFS-1:0]    ofs,
  input  logic [DATA_W-1:0] wdata,
  input  logic [31:0]       rt,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_wdata,
  output logic [NB-1:0]     st_wstrb,
  output logic [1:0]        st_size
);

  logic [1:0]        size;
  logic [6:0]        nbits;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sbit;
  logic [NB-1:0]     strb;
  logic [OFS+2:0]    lsh;
  logic [OFS+2:0]    rsh;

  always_comb begin
    size    = op_size(op);
    nbits   = 7'd8 << size;
    shifted = rdata >> {ofs, 3'b000};
    case (size)
      2'd0:    sbit = shifted[7];
      2'd1:    sbit = shifted[15];
      2'd2:    sbit = shifted[31];
      default: sbit = shifted[DATA_W-1];
    endcase
    // A shift by >= DATA_W yields 0, so full-width accesses keep every bit.
    keep    = ~({DATA_W{1'b1}} << nbits);
    ld_data = (shifted & keep) | (~keep & {DATA_W{op_is_signed(op) & sbit}});

    case (size)
      2'd0:    st_wdata = {NB{wdata[7:0]}};
      2'd1:    st_wdata = {(NB/2){wdata[15:0]}};
      2'd2:    st_wdata = {(NB/4){wdata[31:0]}};
      default: st_wdata = wdata;
    endcase
    case (size)
      2'd0:    strb = NB'(8'h01);
      2'd1:    strb = NB'(8'h03);
      2'd2:    strb = NB'(8'h0F);
      default: strb = {NB{1'b1}};
    endcase
    st_wstrb = strb << ofs;
    st_size  = size;

    rsh = {ofs, 3'b000};
    lsh = {OFS'(NB - 1) - ofs, 3'b000};
`ifdef LSU_LWLR_EN
    // Little-endian MIPS32 unaligned rules: LWL/SWL touch bytes 0..ofs, LWR/SWR bytes ofs..3.
    case (op)
      LSU_OP_LWL: ld_data = (rdata << lsh) | (DATA_W'(rt) & ~({DATA_W{1'b1}} << lsh));
      LSU_OP_LWR: ld_data = (rdata >> rsh) | (DATA_W'(rt) & ~({DATA_W{1'b1}} >> rsh));
      LSU_OP_SWL: begin
        st_wdata = wdata >> lsh;
        st_wstrb = {NB{1'b1}} >> (OFS'(NB - 1) - ofs);
        st_size  = (ofs == OFS'(0)) ? 2'd0 : (ofs == OFS'(1)) ? 2'd1 : 2'd2;
      end
      LSU_OP_SWR: begin
        st_wdata = wdata << rsh;
        st_wstrb = {NB{1'b1}} << ofs;
        st_size  = (ofs == OFS'(NB - 1)) ? 2'd0 : (ofs == OFS'(NB - 2)) ? 2'd1 : 2'd2;
      end
      default: ;
    endcase
`endif
  end

`ifdef LSU_LWLR_EN
  if (DATA_W != 32) begin : g_lwlr_width_check
    $error("LSU_LWLR_EN requires DATA_W == 32");
  end
`else
  logic unused_lwlr;
  assign unused_lwlr = ^{rt, lsh, rsh};
`endif

endmodule

// File: rtl/lsu_sram_like.sv
// MEM-stage load/store unit on an SRAM-like req/addr_ok/data_ok bus with alignment traps and flush survival.
// Optional feature macro: LSU_LWLR_EN enables LWL/LWR/SWL/SWR; otherwise they complete silently with 0.
module lsu_sram_like
  import lsu_sram_like_pkg::*;
#(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned NB     = DATA_W / 8,
  localparam int unsigned OFS    = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [OP_W-1:0]   req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [31:0]       req_rt_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              excp_adel_o,
  output logic              excp_ades_o,
  output logic [ADDR_W-1:0] bad_vaddr_o,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  output logic [NB-1:0]     data_wstrb_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i
);

`ifdef LSU_LWLR_EN
  localparam bit LWLR_EN = 1'b1;
`else
  localparam bit LWLR_EN = 1'b0;
`endif

  logic [2:0]        state, state_d;
  logic              discard_q, discard_d;
  logic [OP_W-1:0]   lat_op;
  logic [OFS-1:0]    lat_ofs;
  logic [31:0]       lat_rt;
  logic              lat_store;
  logic              accept, go_exc, capture, adel_d, ades_d;
  logic              req_store, req_bad, req_mis;
  logic [OP_W-1:0]   al_op;
  logic [OFS-1:0]    al_ofs;
  logic [DATA_W-1:0] ld_data, st_wdata;
  logic [NB-1:0]     st_wstrb;
  logic [1:0]        st_size;

  assign req_store = op_is_store(req_op_i);
  assign req_bad   = !op_known(req_op_i) || (op_is_lwlr(req_op_i) && !LWLR_EN);
  assign req_mis   = misaligned(req_op_i, req_addr_i[2:0]);
  assign stall_o   = req_valid_i & ~resp_valid_o & ~flush_i;

  // Store fields come from the live request at accept; load results from the latched request.
  assign al_op  = (state == S_IDLE) ? req_op_i : lat_op;
  assign al_ofs = (state == S_IDLE) ? req_addr_i[OFS-1:0] : lat_ofs;

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .op       (al_op),
    .ofs      (al_ofs),
    .wdata    (req_wdata_i),
    .rt       (lat_rt),
    .rdata    (data_rdata_i),
    .ld_data  (ld_data),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .st_size  (st_size)
  );

  always_comb begin
    state_d   = state;
    discard_d = discard_q;
    accept    = 1'b0;
    go_exc    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: if (req_valid_i && !flush_i) begin
        if (req_bad || req_mis) begin
          go_exc  = 1'b1;
          state_d = S_EXC;
        end else begin
          accept  = 1'b1;
          state_d = S_ADDR;
        end
      end
      // Once addr_ok is seen the bus owes us data_ok, so a flush can only mark it discarded.
      S_ADDR: if (data_addr_ok_i) begin
        state_d   = S_DATA;
        discard_d = flush_i;
      end else if (flush_i) begin
        state_d = S_IDLE;
      end
      S_DATA: if (data_data_ok_i) begin
        discard_d = 1'b0;
        if (discard_q || flush_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
          capture = 1'b1;
        end
      end else if (flush_i) begin
        discard_d = 1'b1;
      end
      S_RESP, S_EXC: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
    adel_d = go_exc && !req_bad && !req_store;
    ades_d = go_exc && !req_bad && req_store;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      discard_q <= 1'b0;
    end else begin
      state     <= state_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      excp_adel_o  <= 1'b0;
      excp_ades_o  <= 1'b0;
      bad_vaddr_o  <= '0;
      data_req_o   <= 1'b0;
      data_wr_o    <= 1'b0;
      data_size_o  <= 2'd0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
      data_wstrb_o <= '0;
      lat_op       <= '0;
      lat_ofs      <= '0;
      lat_rt       <= '0;
      lat_store    <= 1'b0;
    end else begin
      resp_valid_o <= go_exc || capture;
      excp_adel_o  <= adel_d;
      excp_ades_o  <= ades_d;
      data_req_o   <= (state_d == S_ADDR);
      if (adel_d || ades_d) bad_vaddr_o <= req_addr_i;
      if (go_exc) begin
        resp_rdata_o <= '0;
      end else if (capture) begin
        resp_rdata_o <= lat_store ? '0 : ld_data;
      end
      if (accept) begin
        data_wr_o    <= req_store;
        data_size_o  <= st_size;
        data_addr_o  <= {req_addr_i[ADDR_W-1:OFS], {OFS{1'b0}}};
        data_wdata_o <= req_store ? st_wdata : '0;
        data_wstrb_o <= req_store ? st_wstrb : '0;
        lat_op       <= req_op_i;
        lat_ofs      <= req_addr_i[OFS-1:0];
        lat_rt       <= req_rt_i;
        lat_store    <= req_store;
      end
    end
  end

  a_data_ok_only_in_data: assert property (@(posedge clk) disable iff (rst)
    data_data_ok_i |-> (state == S_DATA))
    else $error("data_data_ok_i outside DATA state");

endmodule
